// File: rtl/ks_pkg.sv
// Shared definitions for the multi-word Kogge-Stone add/subtract sequencer:
// slice width, FSM state encoding and saturation constant builders.
package ks_pkg;

    localparam int SLICE_W = 16;
    // Widest operand supported (16 slices of 16 bits)
    localparam int MAX_W   = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    // Largest positive two's-complement value of width w (0x7FF..F), zero-extended to MAX_W
    function automatic logic [MAX_W-1:0] sat_pos(input int w);
        logic [MAX_W-1:0] r;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            if (i < (w - 1)) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Most negative two's-complement value of width w (0x800..0), zero-extended to MAX_W
    function automatic logic [MAX_W-1:0] sat_neg(input int w);
        logic [MAX_W-1:0] r;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            if (i == (w - 1)) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ks_adder_16.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in. Purely combinational.
// The carry-in is folded into the bit-0 generate term so the prefix tree
// delivers the true carry out of every bit position directly.
module ks_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    localparam int N      = 16;
    localparam int LEVELS = 4;

    logic [N-1:0] g_s [0:LEVELS];
    logic [N-1:0] p_s [0:LEVELS];
    logic [N-1:0] prop_s;
    logic [N-1:0] carry_s;
    int           dist_s;

    // Prefix tree: level l combines each bit with the group 2^(l-1) positions below
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            g_s[l] = {N{1'b0}};
            p_s[l] = {N{1'b0}};
        end
        prop_s    = a ^ b;
        g_s[0]    = a & b;
        g_s[0][0] = (a[0] & b[0]) | (prop_s[0] & cin);
        p_s[0]    = prop_s;
        dist_s    = 32'sd1;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (i >= dist_s) begin
                    g_s[l][i] = g_s[l-1][i] | (p_s[l-1][i] & g_s[l-1][i - dist_s]);
                    p_s[l][i] = p_s[l-1][i] & p_s[l-1][i - dist_s];
                end else begin
                    g_s[l][i] = g_s[l-1][i];
                    p_s[l][i] = p_s[l-1][i];
                end
            end
            dist_s = dist_s * 32'sd2;
        end
        carry_s = {g_s[LEVELS][N-2:0], cin};
        sum     = prop_s ^ carry_s;
        cout    = g_s[LEVELS][N-1];
    end

endmodule

// File: rtl/ks_add_sequencer.sv
// Multi-word add/subtract sequencer. A WORDS*16-bit operand pair is pushed
// through a single 16-bit Kogge-Stone adder one slice per cycle, least
// significant slice first, with the inter-slice carry held in a register.
// Subtraction is A + ~B + 1: B slices are inverted and the carry starts at 1.
//
// Build option: define KS_ADDSEQ_SAT_EN to saturate o_sum on signed overflow
// (0x7F..F for a non-negative A, 0x80..0 for a negative A). Without it the
// result wraps. o_ovf reports the overflow in both builds.
module ks_add_sequencer
    import ks_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WORDS*SLICE_W-1:0]   i_a,
    input  logic [WORDS*SLICE_W-1:0]   i_b,
    input  logic                       i_sub,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WORDS*SLICE_W-1:0]   o_sum,
    output logic                       o_cout,
    output logic                       o_ovf
);

    localparam int                W        = WORDS * SLICE_W;
    localparam int                CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS - 1);

`ifdef KS_ADDSEQ_SAT_EN
    localparam logic [MAX_W-1:0]  SAT_POS_FULL = sat_pos(W);
    localparam logic [MAX_W-1:0]  SAT_NEG_FULL = sat_neg(W);
    localparam logic [W-1:0]      SAT_POS      = SAT_POS_FULL[W-1:0];
    localparam logic [W-1:0]      SAT_NEG      = SAT_NEG_FULL[W-1:0];
`endif

    ks_state_e                     state_r;
    ks_state_e                     state_next_s;
    logic [CNT_W-1:0]              cnt_r;
    logic                          carry_r;
    logic                          sub_r;
    logic                          cout_r;
    logic                          ovf_r;
    logic [WORDS-1:0][SLICE_W-1:0] a_r;
    logic [WORDS-1:0][SLICE_W-1:0] b_r;
    logic [WORDS-1:0][SLICE_W-1:0] sum_r;
    logic [WORDS-1:0][SLICE_W-1:0] sum_next_s;
    logic [SLICE_W-1:0]            a_slice_s;
    logic [SLICE_W-1:0]            b_slice_s;
    logic [SLICE_W-1:0]            add_sum_s;
    logic                          add_cout_s;
    logic                          last_slice_s;
    logic                          ovf_s;

    // Select the active operand slice; B is inverted for subtraction
    always_comb begin
        a_slice_s    = a_r[cnt_r];
        last_slice_s = (cnt_r == LAST_IDX);
        if (sub_r) begin
            b_slice_s = ~b_r[cnt_r];
        end else begin
            b_slice_s = b_r[cnt_r];
        end
    end

    ks_adder_16 u_adder (
        .a    (a_slice_s),
        .b    (b_slice_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Signed overflow of the top slice and the next value of the result register
    always_comb begin
        ovf_s = (a_slice_s[SLICE_W-1] == b_slice_s[SLICE_W-1]) &&
                (add_sum_s[SLICE_W-1] != a_slice_s[SLICE_W-1]);
        sum_next_s        = sum_r;
        sum_next_s[cnt_r] = add_sum_s;
`ifdef KS_ADDSEQ_SAT_EN
        if (last_slice_s && ovf_s) begin
            if (a_slice_s[SLICE_W-1]) begin
                sum_next_s = SAT_NEG;
            end else begin
                sum_next_s = SAT_POS;
            end
        end else begin
            sum_next_s[cnt_r] = add_sum_s;
        end
`endif
    end

    // FSM next state: accept in IDLE, walk slices in RUN, hold result in DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, slice counter, carry chain and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_r     <= i_a;
                        b_r     <= i_b;
                        sub_r   <= i_sub;
                        carry_r <= i_sub;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_next_s;
                    carry_r <= add_cout_s;
                    if (last_slice_s) begin
                        // Counter parks on the last slice; the next accept rewinds it
                        cout_r <= add_cout_s;
                        ovf_r  <= ovf_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    // Result held until the consumer takes it
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state_r == ST_IDLE);
    assign o_valid = (state_r == ST_DONE);
    assign o_sum   = sum_r;
    assign o_cout  = cout_r;
    assign o_ovf   = ovf_r;

endmodule
